// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - byte-stream command parser driving the 8/32 register bus (optional REG_BUS_TIMEOUT_EN)
module reg_bus_master #(
   parameter int RD_LATENCY     = 1,
   parameter int TIMEOUT_CYCLES = 50_000_000
)(
   input  logic        ipClk,
   input  logic        ipReset,
   input  logic [7:0]  ipRxData,
   input  logic        ipRxValid,
   output logic        opRxReady,
   output logic [7:0]  opTxData,
   output logic        opTxValid,
   input  logic        ipTxReady,
   output logic [7:0]  opAddress,
   output logic [31:0] opWrData,
   output logic        opWrEnable,
   input  logic [31:0] ipRdData
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] GET_ADDR  = 3'd1;
   localparam logic [2:0] GET_DATA  = 3'd2;
   localparam logic [2:0] WRITE     = 3'd3;
   localparam logic [2:0] READ_WAIT = 3'd4;
   localparam logic [2:0] SEND      = 3'd5;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;
   localparam logic [7:0] RSP_WRITE = 8'h81;
   localparam logic [7:0] RSP_READ  = 8'h82;
   localparam logic [7:0] RSP_ERROR = 8'hEE;

   localparam int              LAT_W    = $clog2(RD_LATENCY + 2);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY);

   logic [2:0]       state;
   logic [2:0]       stateNext;
   logic             cmdWrite;
   logic [2:0]       byteCnt;
   logic [2:0]       respLast;
   logic [LAT_W-1:0] latCnt;
   logic [31:0]      rdHold;
   logic             rxFire;
   logic             txFire;
   logic             cmdValid;
   logic             timeoutHit;

   assign rxFire     = ipRxValid && opRxReady;
   assign txFire     = opTxValid && ipTxReady;
   assign cmdValid   = (ipRxData == CMD_WRITE) || (ipRxData == CMD_READ);
   assign opWrEnable = (state == WRITE);

`ifdef REG_BUS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] toCnt;

   // Count cycles without a byte while a packet is only partly received.
   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         toCnt <= '0;
      end else if (((state == GET_ADDR) || (state == GET_DATA)) && !rxFire) begin
         toCnt <= toCnt + 1'b1;
      end else begin
         toCnt <= '0;
      end
   end

   assign timeoutHit = ((state == GET_ADDR) || (state == GET_DATA)) && !rxFire &&
                       (toCnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeoutHit = 1'b0;
`endif

   // Next-state decode of the command parser.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:      if (rxFire) stateNext = cmdValid ? GET_ADDR : SEND;
         GET_ADDR:  if (rxFire) stateNext = cmdWrite ? GET_DATA : READ_WAIT;
         GET_DATA:  if (rxFire && (byteCnt == 3'd3)) stateNext = WRITE;
         WRITE:     stateNext = SEND;
         READ_WAIT: if (latCnt == LAT_LAST) stateNext = SEND;
         SEND:      if (txFire && (byteCnt == respLast)) stateNext = IDLE;
         default:   stateNext = IDLE;
      endcase
      if (timeoutHit) begin
         stateNext = IDLE;
      end
   end

   // State register; Rx ready is registered from the next state so it is low under reset.
   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         state     <= IDLE;
         opRxReady <= 1'b0;
      end else begin
         state     <= stateNext;
         opRxReady <= (stateNext == IDLE) || (stateNext == GET_ADDR) || (stateNext == GET_DATA);
      end
   end

   // Field capture, read sampling and response byte sequencing.
   always_ff @(posedge ipClk or posedge ipReset) begin
      if (ipReset) begin
         cmdWrite  <= 1'b0;
         byteCnt   <= '0;
         respLast  <= '0;
         latCnt    <= '0;
         rdHold    <= '0;
         opAddress <= '0;
         opWrData  <= '0;
         opTxData  <= '0;
         opTxValid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (rxFire) begin
                  if (cmdValid) begin
                     cmdWrite <= (ipRxData == CMD_WRITE);
                  end else begin
                     opTxData  <= RSP_ERROR;
                     opTxValid <= 1'b1;
                     byteCnt   <= '0;
                     respLast  <= 3'd0;
                  end
               end
            end
            GET_ADDR: begin
               if (rxFire) begin
                  opAddress <= ipRxData;
                  byteCnt   <= '0;
                  latCnt    <= '0;
               end
            end
            GET_DATA: begin
               if (rxFire) begin
                  opWrData <= {opWrData[23:0], ipRxData};
                  byteCnt  <= byteCnt + 3'd1;
               end
            end
            WRITE: begin
               opTxData  <= RSP_WRITE;
               opTxValid <= 1'b1;
               byteCnt   <= '0;
               respLast  <= 3'd0;
            end
            READ_WAIT: begin
               if (latCnt == LAT_LAST) begin
                  rdHold    <= ipRdData;
                  opTxData  <= RSP_READ;
                  opTxValid <= 1'b1;
                  byteCnt   <= '0;
                  respLast  <= 3'd4;
               end else begin
                  latCnt <= latCnt + 1'b1;
               end
            end
            SEND: begin
               if (txFire) begin
                  if (byteCnt == respLast) begin
                     opTxValid <= 1'b0;
                  end else begin
                     opTxData <= rdHold[31:24];
                     rdHold   <= {rdHold[23:0], 8'h00};
                     byteCnt  <= byteCnt + 3'd1;
                  end
               end
            end
            default: begin
               opTxValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed self-checking bench for reg_bus_master
module tb_reg_bus_master;

   logic        ipClk = 1'b0;
   logic        ipReset = 1'b1;
   logic [7:0]  ipRxData = 8'h00;
   logic        ipRxValid = 1'b0;
   logic        opRxReady;
   logic [7:0]  opTxData;
   logic        opTxValid;
   logic        ipTxReady = 1'b1;
   logic [7:0]  opAddress;
   logic [31:0] opWrData;
   logic        opWrEnable;
   logic [31:0] ipRdData = 32'h0;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [0:255];

   int          cyc = 0;
   int          wrCount = 0;
   logic [7:0]  lastWrAddr = 8'h00;
   logic [31:0] lastWrData = 32'h0;
   int          wrCyc = 0;
   int          rxCyc = 0;
   logic [7:0]  txQ [$];
   int          txCyc [$];

   reg_bus_master #(.RD_LATENCY(1), .TIMEOUT_CYCLES(100)) dut (
      .ipClk(ipClk), .ipReset(ipReset),
      .ipRxData(ipRxData), .ipRxValid(ipRxValid), .opRxReady(opRxReady),
      .opTxData(opTxData), .opTxValid(opTxValid), .ipTxReady(ipTxReady),
      .opAddress(opAddress), .opWrData(opWrData), .opWrEnable(opWrEnable),
      .ipRdData(ipRdData)
   );

   initial forever #5 ipClk = ~ipClk;

   // register file slave: read data registered once after the address
   always @(posedge ipClk) ipRdData <= mem[opAddress];

   // bus and stream monitor
   always @(posedge ipClk) begin
      cyc++;
      if (opWrEnable) begin
         wrCount++;
         lastWrAddr = opAddress;
         lastWrData = opWrData;
         wrCyc = cyc;
      end
      if (ipRxValid && opRxReady) rxCyc = cyc;
      if (opTxValid && ipTxReady) begin
         txQ.push_back(opTxData);
         txCyc.push_back(cyc);
      end
   end

   task automatic sendByte(input logic [7:0] b);
      int n = 0;
      @(negedge ipClk);
      ipRxData = b;
      ipRxValid = 1'b1;
      while (!opRxReady && n < 200) begin
         @(negedge ipClk);
         n++;
      end
      checks++;
      if (!opRxReady) begin
         errors++;
         $display("FAIL rx_accept: byte %02h not accepted after %0d cycles, required accept", b, n);
      end
      @(posedge ipClk);
      #1 ipRxValid = 1'b0;
   endtask

   task automatic waitTx(input int n);
      int k = 0;
      while (txQ.size() < n && k < 300) begin
         @(negedge ipClk);
         k++;
      end
      checks++;
      if (txQ.size() < n) begin
         errors++;
         $display("FAIL tx_wait: got %0d bytes, required %0d", txQ.size(), n);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge ipClk);
      checks++; if (opRxReady !== 1'b0) begin errors++; $display("FAIL rst_rxready: got %b, required 0", opRxReady); end
      checks++; if (opTxValid !== 1'b0) begin errors++; $display("FAIL rst_txvalid: got %b, required 0", opTxValid); end
      checks++; if (opTxData !== 8'h00) begin errors++; $display("FAIL rst_txdata: got %02h, required 00", opTxData); end
      checks++; if (opAddress !== 8'h00) begin errors++; $display("FAIL rst_addr: got %02h, required 00", opAddress); end
      checks++; if (opWrData !== 32'h0) begin errors++; $display("FAIL rst_wrdata: got %08h, required 0", opWrData); end
      checks++; if (opWrEnable !== 1'b0) begin errors++; $display("FAIL rst_wren: got %b, required 0", opWrEnable); end
      ipReset = 1'b0;
      repeat (2) @(negedge ipClk);
      checks++; if (opRxReady !== 1'b1) begin errors++; $display("FAIL idle_rxready: got %b, required 1", opRxReady); end
   endtask

   task automatic test_write;
      int base = txQ.size();
      int w0 = wrCount;
      sendByte(8'h01); sendByte(8'h04); sendByte(8'h12);
      sendByte(8'h34); sendByte(8'h56); sendByte(8'h78);
      waitTx(base + 1);
      repeat (3) @(negedge ipClk);
      checks++; if (wrCount - w0 !== 1) begin errors++; $display("FAIL wr_pulses: got %0d, required 1", wrCount - w0); end
      checks++; if (lastWrAddr !== 8'h04) begin errors++; $display("FAIL wr_addr: got %02h, required 04", lastWrAddr); end
      checks++; if (lastWrData !== 32'h12345678) begin errors++; $display("FAIL wr_data: got %08h, required 12345678", lastWrData); end
      checks++; if (txQ.size() !== base + 1) begin errors++; $display("FAIL wr_rsp_len: got %0d, required %0d", txQ.size(), base + 1); end
      if (txQ.size() > base) begin
         checks++; if (txQ[base] !== 8'h81) begin errors++; $display("FAIL wr_rsp: got %02h, required 81", txQ[base]); end
         checks++; if (txCyc[base] - wrCyc !== 1) begin errors++; $display("FAIL wr_latency: got %0d, required 1", txCyc[base] - wrCyc); end
      end
      checks++; if (opAddress !== 8'h04) begin errors++; $display("FAIL wr_addr_hold: got %02h, required 04", opAddress); end
   endtask

   task automatic test_read;
      logic [7:0] exp [5];
      int base = txQ.size();
      int w0 = wrCount;
      exp = '{8'h82, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      mem[0] = 32'hDEADBEEF;
      sendByte(8'h02); sendByte(8'h00);
      waitTx(base + 5);
      repeat (3) @(negedge ipClk);
      checks++; if (txQ.size() !== base + 5) begin errors++; $display("FAIL rd_len: got %0d, required %0d", txQ.size(), base + 5); end
      for (int i = 0; i < 5; i++) begin
         if (txQ.size() > base + i) begin
            checks++;
            if (txQ[base + i] !== exp[i]) begin errors++; $display("FAIL rd_byte%0d: got %02h, required %02h", i, txQ[base + i], exp[i]); end
         end
      end
      if (txQ.size() > base) begin
         checks++; if (txCyc[base] - rxCyc !== 3) begin errors++; $display("FAIL rd_latency: got %0d, required 3", txCyc[base] - rxCyc); end
      end
      checks++; if (wrCount !== w0) begin errors++; $display("FAIL rd_no_write: got %0d pulses, required 0", wrCount - w0); end
      checks++; if (opWrData !== 32'h12345678) begin errors++; $display("FAIL rd_wrdata_hold: got %08h, required 12345678", opWrData); end
   endtask

   task automatic test_back_pressure;
      logic [7:0] exp [5];
      logic [7:0] held;
      int base = txQ.size();
      int rdyBad = 0;
      int holdBad = 0;
      int rx0;
      int k = 0;
      exp = '{8'h82, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
      mem[8'h10] = 32'hCAFEF00D;
      sendByte(8'h02); sendByte(8'h10);
      rx0 = rxCyc;
      waitTx(base + 2);
      ipTxReady = 1'b0;
      mem[8'h10] = 32'h11111111;
      ipRxData = 8'h01;
      ipRxValid = 1'b1;
      held = opTxData;
      repeat (20) begin
         @(negedge ipClk);
         if (opRxReady) rdyBad++;
         if (!opTxValid || opTxData !== held) holdBad++;
      end
      ipRxValid = 1'b0;
      checks++; if (held !== 8'hFE) begin errors++; $display("FAIL bp_held_byte: got %02h, required FE", held); end
      checks++; if (holdBad !== 0) begin errors++; $display("FAIL bp_tx_stable: got %0d unstable cycles, required 0", holdBad); end
      checks++; if (txQ.size() !== base + 2) begin errors++; $display("FAIL bp_no_transfer: got %0d, required %0d", txQ.size(), base + 2); end
      ipTxReady = 1'b1;
      while (txQ.size() < base + 5 && k < 50) begin
         @(negedge ipClk);
         k++;
         if (txQ.size() < base + 5 && opRxReady) rdyBad++;
      end
      repeat (3) @(negedge ipClk);
      checks++; if (rdyBad !== 0) begin errors++; $display("FAIL bp_rxready: got %0d ready cycles, required 0", rdyBad); end
      checks++; if (rxCyc !== rx0) begin errors++; $display("FAIL bp_rx_blocked: got accept at %0d, required none after %0d", rxCyc, rx0); end
      checks++; if (txQ.size() !== base + 5) begin errors++; $display("FAIL bp_len: got %0d, required %0d", txQ.size(), base + 5); end
      for (int i = 0; i < 5; i++) begin
         if (txQ.size() > base + i) begin
            checks++;
            if (txQ[base + i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d: got %02h, required %02h", i, txQ[base + i], exp[i]); end
         end
      end
      checks++; if (opRxReady !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b, required 1", opRxReady); end
   endtask

   task automatic test_bad_command;
      logic [7:0] exp [5];
      int base = txQ.size();
      int base2;
      exp = '{8'h82, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
      sendByte(8'h7F);
      waitTx(base + 1);
      repeat (2) @(negedge ipClk);
      checks++; if (txQ.size() !== base + 1) begin errors++; $display("FAIL bad_len: got %0d, required %0d", txQ.size(), base + 1); end
      if (txQ.size() > base) begin
         checks++; if (txQ[base] !== 8'hEE) begin errors++; $display("FAIL bad_rsp: got %02h, required EE", txQ[base]); end
      end
      checks++; if (opRxReady !== 1'b1) begin errors++; $display("FAIL bad_idle: got %b, required 1", opRxReady); end
      mem[3] = 32'h0BADF00D;
      base2 = txQ.size();
      sendByte(8'h02); sendByte(8'h03);
      waitTx(base2 + 5);
      for (int i = 0; i < 5; i++) begin
         if (txQ.size() > base2 + i) begin
            checks++;
            if (txQ[base2 + i] !== exp[i]) begin errors++; $display("FAIL bad_next_byte%0d: got %02h, required %02h", i, txQ[base2 + i], exp[i]); end
         end
      end
   endtask

   task automatic test_reset_mid_packet;
      int base = txQ.size();
      int w0 = wrCount;
      int base2;
      sendByte(8'h01); sendByte(8'h02); sendByte(8'hAA);
      @(negedge ipClk);
      #2 ipReset = 1'b1;
      #1;
      checks++;
      if ({opRxReady, opTxValid, opTxData, opAddress, opWrData, opWrEnable} !== 51'h0) begin
         errors++;
         $display("FAIL mid_rst_outputs: got rdy=%b tv=%b td=%02h a=%02h d=%08h we=%b, required all 0",
                  opRxReady, opTxValid, opTxData, opAddress, opWrData, opWrEnable);
      end
      repeat (3) @(posedge ipClk);
      #2 ipReset = 1'b0;
      repeat (5) @(negedge ipClk);
      checks++; if (wrCount !== w0) begin errors++; $display("FAIL mid_rst_no_write: got %0d pulses, required 0", wrCount - w0); end
      checks++; if (txQ.size() !== base) begin errors++; $display("FAIL mid_rst_no_tx: got %0d bytes, required 0", txQ.size() - base); end
      checks++; if (opRxReady !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b, required 1", opRxReady); end
      base2 = txQ.size();
      sendByte(8'h01); sendByte(8'h07); sendByte(8'hA1);
      sendByte(8'hB2); sendByte(8'hC3); sendByte(8'hD4);
      waitTx(base2 + 1);
      checks++; if (wrCount - w0 !== 1) begin errors++; $display("FAIL mid_rst_wr_pulses: got %0d, required 1", wrCount - w0); end
      checks++; if (lastWrAddr !== 8'h07) begin errors++; $display("FAIL mid_rst_wr_addr: got %02h, required 07", lastWrAddr); end
      checks++; if (lastWrData !== 32'hA1B2C3D4) begin errors++; $display("FAIL mid_rst_wr_data: got %08h, required A1B2C3D4", lastWrData); end
      if (txQ.size() > base2) begin
         checks++; if (txQ[base2] !== 8'h81) begin errors++; $display("FAIL mid_rst_rsp: got %02h, required 81", txQ[base2]); end
      end
   endtask

`ifdef REG_BUS_TIMEOUT_EN
   task automatic test_timeout;
      logic [7:0] exp [5];
      int base = txQ.size();
      int w0 = wrCount;
      exp = '{8'h82, 8'h5A, 8'h5A, 8'hA5, 8'hA5};
      mem[5] = 32'h5A5AA5A5;
      sendByte(8'h01); sendByte(8'h05);
      repeat (150) @(negedge ipClk);
      checks++; if (txQ.size() !== base) begin errors++; $display("FAIL to_silent: got %0d bytes, required 0", txQ.size() - base); end
      sendByte(8'h02); sendByte(8'h05);
      waitTx(base + 5);
      repeat (3) @(negedge ipClk);
      checks++; if (wrCount !== w0) begin errors++; $display("FAIL to_no_write: got %0d pulses, required 0", wrCount - w0); end
      checks++; if (txQ.size() !== base + 5) begin errors++; $display("FAIL to_len: got %0d, required %0d", txQ.size(), base + 5); end
      for (int i = 0; i < 5; i++) begin
         if (txQ.size() > base + i) begin
            checks++;
            if (txQ[base + i] !== exp[i]) begin errors++; $display("FAIL to_byte%0d: got %02h, required %02h", i, txQ[base + i], exp[i]); end
         end
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      test_reset;
      test_write;
      test_read;
      test_back_pressure;
      test_bad_command;
      test_reset_mid_packet;
`ifdef REG_BUS_TIMEOUT_EN
      test_timeout;
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator side of the 8-bit-address / 32-bit-data memory-mapped register bus.
- Parses a byte-stream command protocol, normally fed by the UART receiver.
- Issues single register writes and reads on the bus.
- Returns responses as a byte stream, normally to the UART transmitter.
- Sits between the UART stream ports and the register file, so the host PC gets full register access.

Parameters:
- RD_LATENCY, 1: clock cycles from opAddress being driven until ipRdData is valid. The register file registers read data once, so 1.
- TIMEOUT_CYCLES, 50_000_000: inter-byte timeout in ipClk cycles. Used only when REG_BUS_TIMEOUT_EN is defined.

Ports:
- ipClk  in  1  system clock
- ipReset  in  1  asynchronous reset, active-high
- ipRxData  in  8  command stream byte
- ipRxValid  in  1  ipRxData valid
- opRxReady  out  1  block accepts ipRxData this cycle
- opTxData  out  8  response stream byte
- opTxValid  out  1  opTxData valid
- ipTxReady  in  1  sink accepts opTxData this cycle
- opAddress  out  8  register address
- opWrData  out  32  register write data
- opWrEnable  out  1  single-cycle write strobe
- ipRdData  in  32  register read data

Behaviour:
- Handshakes:
  - Rx byte transfers when ipRxValid && opRxReady at a rising edge.
  - Tx byte transfers when opTxValid && ipTxReady.
  - opTxData and opTxValid hold stable until the transfer completes.
- Reset (asynchronous, any state) forces state IDLE and drives all outputs to 0, including opRxReady. The byte counter and shift registers clear.
- Reset mid-packet aborts the packet with no bus access and no response.
- Command packet, all multi-byte fields MSB first:
  - Write: 0x01, addr, d3, d2, d1, d0
  - Read: 0x02, addr
- Response:
  - Write: single byte 0x81
  - Read: 0x82, then 4 data bytes MSB first
  - Unknown command byte: single byte 0xEE, then the parser returns to IDLE
- States:
  - IDLE: opRxReady=1. On a received byte:
    - 0x01 or 0x02 → GET_ADDR, with the command latched
    - anything else → response byte 0xEE, then SEND
  - GET_ADDR: opRxReady=1. Received byte is latched into opAddress.
    - Write command → GET_DATA with byte count 0
    - Read command → READ_WAIT
  - GET_DATA: opRxReady=1. Each byte shifts into opWrData from the LSB end. After the 4th byte → WRITE.
  - WRITE: opRxReady=0. opWrEnable=1 for exactly one cycle with opAddress and opWrData stable. Next state SEND, response 0x81.
  - READ_WAIT: opRxReady=0. opAddress is held for RD_LATENCY cycles. ipRdData is then sampled into a 32-bit holding register. Next state SEND with a 5-byte response.
  - SEND: opRxReady=0. Response bytes are presented one per completed transfer. A byte counter runs to 0 (1 byte) or 4 (5 bytes). After the last transfer → IDLE.
- Bus signals:
  - opWrEnable is never high outside WRITE.
  - opAddress and opWrData keep their last values between commands and are not cleared.
- Read data is captured exactly once. Later changes on ipRdData during a stalled SEND (ipTxReady=0) must not alter the response.
- Throughput: no new Rx bytes are accepted until the response has been fully sent.
  - Write round trip: WRITE → 0x81 valid on the next cycle.
  - Read round trip: address byte accepted → first response byte valid after RD_LATENCY+1 cycles.

Optional Feature:
- Macro: REG_BUS_TIMEOUT_EN
- Defined:
  - A counter runs while in GET_ADDR or GET_DATA and resets on every accepted byte.
  - When the counter reaches TIMEOUT_CYCLES, the partial packet is discarded: no bus access, no response, back to IDLE.
- Not defined: no counter is synthesised, and the parser waits indefinitely for the remaining bytes.

Test Plan:
- Write path: send 01 04 12 34 56 78 → one opWrEnable pulse with opAddress=0x04, opWrData=0x12345678; then Tx 0x81.
- Read path: slave model returns 0xDEADBEEF one cycle after address 0x00; send 02 00 → Tx 82 DE AD BE EF; opWrEnable stays 0 throughout.
- Back-pressure: hold ipTxReady=0 for 20 cycles mid-read-response and change ipRdData → remaining bytes still match the captured value, none lost or duplicated; opRxReady=0 until the final byte transfers.
- Bad command: send 0x7F → Tx 0xEE; a following 02 03 read completes normally.
- Reset mid-packet: send 01 02 AA, assert ipReset asynchronously for 3 cycles → no opWrEnable, no Tx, all outputs 0; a following full write succeeds.
- Timeout (with REG_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=100): send 01 05, idle 150 cycles, then 02 05 → first packet dropped silently; read response 82 plus 4 data bytes returned.
